qspi_mem_responder: RTL and testbench
=====================================

Name: qspi_mem_responder

Overview:
Synthesizable QSPI flash responder: the target side of the quad-SPI link that the MMU drives as initiator on its external storage port. It decodes QPI-mode read/write commands, serves data from an internal byte array, and accepts writes into that array. It replaces the passive stub for system-level and FPGA runs. A backdoor port gives the bench direct load/inspect access.

Parameters:
MEM_BYTES, 4096, size of the backing byte array (power of 2); address bits above log2(MEM_BYTES) are ignored.
DUMMY_CYCLES, 4, number of SCK cycles between the last address nibble and the first read-data nibble.
CMD_READ, 8'hEB, opcode for quad read.
CMD_WRITE, 8'h38, opcode for quad write.

Ports:
clk  input  1  system clock; SCK is sampled in this domain.
rst  input  1  synchronous active-high reset.
qspi_ck_o  input  1  SCK from the initiator; idle low (mode 0).
qspi_cs_o  input  1  chip select from the initiator, active low.
qspi_io_o  input  4  data driven by the initiator.
qspi_io_t  input  4  initiator tristate; 1 = initiator not driving.
qspi_io_i  output  4  data returned to the initiator.
resp_oe  output  1  1 while the responder drives qspi_io_i (read-data phase only).
cmd_err  output  1  one-clk pulse when an unknown opcode completes.
dbg_we  input  1  backdoor write strobe.
dbg_addr  input  log2(MEM_BYTES)  backdoor byte address.
dbg_wdata  input  8  backdoor write data.
dbg_rdata  output  8  backdoor read data, combinational from dbg_addr.

Behaviour:
- Reset values: qspi_io_i=0, resp_oe=0, cmd_err=0, state=IDLE. The array is not cleared.
- Edge detection:
  - Register ck_q <= qspi_ck_o.
  - Rise = qspi_ck_o & ~ck_q; fall = ~qspi_ck_o & ck_q.
  - Each SCK phase must last >=2 clk cycles; shorter phases are out of spec.
- Mode 0 timing: the responder samples qspi_io_o on rise and updates qspi_io_i on fall. Nibbles are MSB-first.
- States:
  - IDLE: leave on a clk where qspi_cs_o=0, go to CMD.
  - CMD: 2 rises build the opcode. On the 2nd rise: READ or WRITE goes to ADDR; any other opcode goes to DISCARD with cmd_err pulsed the next clk.
  - ADDR: 6 rises build a 24-bit address (low bits used).
    - READ: after ADDR go to DUMMY. If DUMMY_CYCLES=0, go straight to RDATA and drive the first nibble on the fall after the last address rise.
    - WRITE: after ADDR go to WDATA.
  - DUMMY: count DUMMY_CYCLES rises. The fall following the last dummy rise sets resp_oe=1 and qspi_io_i=mem[addr][7:4]; enter RDATA.
  - RDATA:
    - Each fall alternates low nibble then high nibble.
    - After the low nibble is driven, addr <= addr+1, wrapping at MEM_BYTES.
    - Streams indefinitely.
  - WDATA:
    - The 1st rise latches the high nibble; the 2nd rise writes the byte to mem[addr] on that clk, then addr <= addr+1 with wrap.
    - A partial byte at CS deassert is discarded.
  - DISCARD: ignore SCK until CS deasserts.
- qspi_cs_o=1 in any state: on the next clk, state=IDLE, resp_oe=0, qspi_io_i=0, and counters and nibble toggle cleared.
- Edges while qspi_cs_o=1 are ignored.
- rst asserted mid-transaction: same as CS deassert. A write already committed stays committed.
- Backdoor write:
  - dbg_we writes on the clk edge.
  - On a same-clk collision with a WDATA commit, the backdoor wins and the protocol write to that address is dropped. Protocol writes to other addresses are unaffected.
- resp_oe=1 while qspi_io_t != 4'hF is a bus conflict. Behaviour is unchanged; the bench flags it.

Decomposition:
- Package qspi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, DISCARD);
  - opcode constants (CMD_READ/CMD_WRITE defaults);
  - ADDR_NIBBLES=6.
  The MMU initiator imports the same package.
- Sub-module qspi_sck_edge: registered edge detector producing rise/fall pulses. It is reused by any other SPI target in the design.

Test Plan:
- Backdoor load mem[0x010..0x013]=DE AD BE EF. Send CS low, EB, 000010, 4 dummy, read 8 nibbles -> qspi_io_i sequence D,E,A,D,B,E,E,F; resp_oe rises on the fall after the 4th dummy rise.
- Quad write 38, 000020, nibbles 1,2,3,4,5 then CS high -> dbg_rdata[0x20]=12, [0x21]=34; [0x22] unchanged (partial byte dropped).
- Read at 0xFFF with MEM_BYTES=4096, mem[0xFFF]=AA, mem[0x000]=55, 4 nibbles -> A,A,5,5 (address wraps).
- Opcode 0x9F -> cmd_err single-clk pulse; further SCK activity produces no writes and resp_oe stays 0 until CS high.
- CS deasserted after 3 address nibbles, then a fresh EB read of 0x010 -> correct data; no residue from the aborted transfer.
- rst pulsed during RDATA -> next clk resp_oe=0, qspi_io_i=0, state IDLE; array contents intact on the following read.

Source files
------------

// File: rtl/qspi_pkg.sv
// qspi_pkg
// Shared definitions for the quad-SPI link: responder FSM states, default
// opcodes and the fixed address length. The MMU initiator imports this same
// package so both ends of the link agree on opcodes and address width.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        DISCARD
    } qspi_state_e;

    localparam logic [7:0] CMD_READ_DEFAULT  = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h38;

    // Addresses are always sent as 24 bits, one nibble per SCK cycle
    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_sck_edge.sv
// qspi_sck_edge
// Registered SCK edge detector. SCK is treated as an ordinary input sampled
// in the system clock domain; each SCK phase must last at least two clk
// cycles for every edge to be seen.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_sck   serial clock from the initiator
//   o_rise  one-clk pulse on an SCK rising edge
//   o_fall  one-clk pulse on an SCK falling edge
module qspi_sck_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    output logic o_rise,
    output logic o_fall
);

    logic r_ckQ;

    // Previous SCK level; reset to the mode-0 idle level so no edge is
    // reported straight out of reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ckQ <= 1'b0;
        end else begin
            r_ckQ <= i_sck;
        end
    end

    assign o_rise = i_sck & ~r_ckQ;
    assign o_fall = ~i_sck & r_ckQ;

endmodule

// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder
// Target side of the QPI-mode quad-SPI link. Decodes quad read/write
// commands from the initiator, serves read data from an internal byte array
// and commits write data into it. A backdoor port gives direct load and
// inspect access to the array.
// Ports:
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_qspi_ck_o           SCK from the initiator (mode 0, idle low)
//   i_qspi_cs_o           chip select, active low
//   i_qspi_io_o           nibble driven by the initiator
//   i_qspi_io_t           initiator tristate (1 = not driving), monitor only
//   o_qspi_io_i           nibble returned to the initiator
//   o_resp_oe             high while the responder drives read data
//   o_cmd_err             one-clk pulse after an unknown opcode
//   i_dbg_we/addr/wdata   backdoor write port
//   o_dbg_rdata           backdoor read data, combinational from i_dbg_addr
module qspi_mem_responder
    import qspi_pkg::*;
#(
    parameter int          MEM_BYTES    = 4096,
    parameter int          DUMMY_CYCLES = 4,
    parameter logic [7:0]  CMD_READ     = CMD_READ_DEFAULT,
    parameter logic [7:0]  CMD_WRITE    = CMD_WRITE_DEFAULT,
    localparam int         AW           = $clog2(MEM_BYTES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_qspi_ck_o,
    input  logic          i_qspi_cs_o,
    input  logic [3:0]    i_qspi_io_o,
    input  logic [3:0]    i_qspi_io_t,
    output logic [3:0]    o_qspi_io_i,
    output logic          o_resp_oe,
    output logic          o_cmd_err,
    input  logic          i_dbg_we,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [7:0]    i_dbg_wdata,
    output logic [7:0]    o_dbg_rdata
);

    logic [7:0]  r_mem [MEM_BYTES];

    qspi_state_e r_state;
    logic [7:0]  r_opcode;
    logic [23:0] r_addr;
    logic [7:0]  r_cnt;
    logic        r_phase;
    logic        r_isWrite;
    logic [3:0]  r_wHi;
    logic [3:0]  r_ioOut;
    logic        r_oe;
    logic        r_cmdErr;

    logic          w_rise;
    logic          w_fall;
    logic [7:0]    w_opNext;
    logic [AW-1:0] w_memIdx;
    logic          w_protoWe;
    logic [7:0]    w_protoData;
    logic          w_unusedIoT;

    qspi_sck_edge u_sckEdge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sck  (i_qspi_ck_o),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // The initiator's tristate only matters to an external bus-conflict check
    assign w_unusedIoT = ^i_qspi_io_t;

    assign w_opNext    = {r_opcode[3:0], i_qspi_io_o};
    assign w_memIdx    = r_addr[AW-1:0];
    assign w_protoData = {r_wHi, i_qspi_io_o};

    // The second rise of a WDATA byte commits it on that very clk; reset or
    // a deasserted chip select abandon the byte instead
    assign w_protoWe = !i_rst && !i_qspi_cs_o && (r_state == WDATA) && w_rise && r_phase;

    // Backdoor has priority on an address collision; a protocol write to a
    // different address in the same clk still lands
    always_ff @(posedge i_clk) begin
        if (w_protoWe && !(i_dbg_we && (i_dbg_addr == w_memIdx))) begin
            r_mem[w_memIdx] <= w_protoData;
        end
        if (i_dbg_we) begin
            r_mem[i_dbg_addr] <= i_dbg_wdata;
        end
    end

    assign o_dbg_rdata = r_mem[i_dbg_addr];

    // Protocol FSM. r_phase selects the nibble half: in RDATA 0 means the
    // next fall drives the high nibble, in WDATA 0 means the next rise
    // carries the high nibble. Address bits above AW are shifted in but
    // never used, which makes the increment wrap at MEM_BYTES for free.
    always_ff @(posedge i_clk) begin
        r_cmdErr <= 1'b0;
        if (i_rst || i_qspi_cs_o) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
            r_ioOut <= 4'h0;
            r_cnt   <= 8'd0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= CMD;
                    r_cnt   <= 8'd0;
                    r_phase <= 1'b0;
                end
                CMD: begin
                    if (w_rise) begin
                        r_opcode <= w_opNext;
                        r_cnt    <= r_cnt + 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_cnt <= 8'd0;
                            if (w_opNext == CMD_READ) begin
                                r_isWrite <= 1'b0;
                                r_state   <= ADDR;
                            end else if (w_opNext == CMD_WRITE) begin
                                r_isWrite <= 1'b1;
                                r_state   <= ADDR;
                            end else begin
                                r_state  <= DISCARD;
                                r_cmdErr <= 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (w_rise) begin
                        r_addr <= {r_addr[19:0], i_qspi_io_o};
                        r_cnt  <= r_cnt + 8'd1;
                        if (r_cnt == 8'(ADDR_NIBBLES - 1)) begin
                            r_cnt   <= 8'd0;
                            r_phase <= 1'b0;
                            if (r_isWrite) begin
                                r_state <= WDATA;
                            end else if (DUMMY_CYCLES == 0) begin
                                r_state <= RDATA;
                            end else begin
                                r_state <= DUMMY;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (w_rise && (r_cnt != 8'(DUMMY_CYCLES))) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (w_fall && (r_cnt == 8'(DUMMY_CYCLES))) begin
                        r_ioOut <= r_mem[w_memIdx][7:4];
                        r_oe    <= 1'b1;
                        r_phase <= 1'b1;
                        r_state <= RDATA;
                    end
                end
                RDATA: begin
                    if (w_fall) begin
                        r_oe <= 1'b1;
                        if (!r_phase) begin
                            r_ioOut <= r_mem[w_memIdx][7:4];
                            r_phase <= 1'b1;
                        end else begin
                            r_ioOut <= r_mem[w_memIdx][3:0];
                            r_addr  <= r_addr + 24'd1;
                            r_phase <= 1'b0;
                        end
                    end
                end
                WDATA: begin
                    if (w_rise) begin
                        if (!r_phase) begin
                            r_wHi   <= i_qspi_io_o;
                            r_phase <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 24'd1;
                            r_phase <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    r_state <= DISCARD;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_qspi_io_i = r_ioOut;
    assign o_resp_oe   = r_oe;
    assign o_cmd_err   = r_cmdErr;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// tb_qspi_mem_responder
// Directed bench for the QSPI responder. Read tasks push the expected data
// nibbles into a queue; a monitor on SCK rises pops and compares whenever
// the responder is driving the bus. Backdoor reads and control outputs are
// compared directly against hand-computed values.
module tb_qspi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        cs  = 1'b1;
    logic [3:0]  ioO = 4'h0;
    logic [3:0]  ioT = 4'hF;
    logic [3:0]  ioI;
    logic        oe;
    logic        cmdErr;
    logic        dbgWe = 1'b0;
    logic [11:0] dbgAddr = 12'h000;
    logic [7:0]  dbgWdata = 8'h00;
    logic [7:0]  dbgRdata;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  expQ [$];
    logic [3:0]  monExp;
    int          errCycles = 0;
    bit          oeSeen = 1'b0;

    qspi_mem_responder #(
        .MEM_BYTES    (4096),
        .DUMMY_CYCLES (4),
        .CMD_READ     (8'hEB),
        .CMD_WRITE    (8'h38)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_qspi_ck_o (sck),
        .i_qspi_cs_o (cs),
        .i_qspi_io_o (ioO),
        .i_qspi_io_t (ioT),
        .o_qspi_io_i (ioI),
        .o_resp_oe   (oe),
        .o_cmd_err   (cmdErr),
        .i_dbg_we    (dbgWe),
        .i_dbg_addr  (dbgAddr),
        .i_dbg_wdata (dbgWdata),
        .o_dbg_rdata (dbgRdata)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Hard stop so a wedged run still reports
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: the initiator samples read data on SCK rise
    always @(posedge sck) begin
        if (!cs && oe) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL readNibble: got %0h, expected no data", ioI);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("readNibble", {28'd0, ioI}, {28'd0, monExp});
            end
        end
    end

    // Track cmd_err width, any responder drive, and bus conflicts
    always @(negedge clk) begin
        if (cmdErr) errCycles++;
        if (oe) oeSeen = 1'b1;
        if (oe && (ioT != 4'hF)) begin
            checks++;
            errors++;
            $display("[TB] FAIL busConflict: io_t=%0h while resp_oe=1", ioT);
        end
    end

    task automatic sckPulse();
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendNibble(input logic [3:0] n);
        ioO = n;
        ioT = 4'h0;
        @(negedge clk);
        sckPulse();
    endtask

    task automatic startCmd(input logic [7:0] op);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        sendNibble(op[7:4]);
        sendNibble(op[3:0]);
    endtask

    task automatic sendAddr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sendNibble(a[4*i +: 4]);
    endtask

    // Four dummy cycles; the responder must take the bus only on the fall
    // after the fourth dummy rise
    task automatic dummyPhase();
        ioT = 4'hF;
        repeat (3) sckPulse();
        sck = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("oeBeforeLastDummyFall", {31'd0, oe}, 32'd0);
        sck = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("oeAfterLastDummyFall", {31'd0, oe}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic readData(input logic [31:0] expNibs, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(expNibs[4*(n-1-i) +: 4]);
            sckPulse();
        end
    endtask

    task automatic endXfer();
        cs  = 1'b1;
        ioT = 4'hF;
        repeat (2) @(negedge clk);
        checkOutput("oeAfterCsHigh", {31'd0, oe}, 32'd0);
        checkOutput("ioAfterCsHigh", {28'd0, ioI}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // One complete quad read transaction
    task automatic applyStimulus(input logic [23:0] a, input logic [31:0] expNibs, input int n);
        startCmd(8'hEB);
        sendAddr(a);
        dummyPhase();
        readData(expNibs, n);
        endXfer();
    endtask

    task automatic backdoorWrite(input logic [11:0] a, input logic [7:0] d);
        dbgAddr  = a;
        dbgWdata = d;
        dbgWe    = 1'b1;
        @(negedge clk);
        dbgWe    = 1'b0;
    endtask

    task automatic backdoorCheck(input string name, input logic [11:0] a, input logic [7:0] d);
        dbgAddr = a;
        #1;
        checkOutput(name, {24'd0, dbgRdata}, {24'd0, d});
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("resetIo", {28'd0, ioI}, 32'd0);
        checkOutput("resetOe", {31'd0, oe}, 32'd0);
        checkOutput("resetCmdErr", {31'd0, cmdErr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Backdoor preload
        backdoorWrite(12'h010, 8'hDE);
        backdoorWrite(12'h011, 8'hAD);
        backdoorWrite(12'h012, 8'hBE);
        backdoorWrite(12'h013, 8'hEF);
        backdoorWrite(12'hFFF, 8'hAA);
        backdoorWrite(12'h000, 8'h55);
        backdoorWrite(12'h022, 8'h77);
        backdoorCheck("preload010", 12'h010, 8'hDE);

        // Basic quad read
        applyStimulus(24'h000010, 32'hDEADBEEF, 8);

        // Quad write with a trailing partial byte
        startCmd(8'h38);
        sendAddr(24'h000020);
        sendNibble(4'h1);
        sendNibble(4'h2);
        sendNibble(4'h3);
        sendNibble(4'h4);
        sendNibble(4'h5);
        endXfer();
        backdoorCheck("write020", 12'h020, 8'h12);
        backdoorCheck("write021", 12'h021, 8'h34);
        backdoorCheck("partial022", 12'h022, 8'h77);

        // Read across the top of the array
        applyStimulus(24'h000FFF, 32'h0000AA55, 4);

        // Backdoor write colliding with a protocol commit to the same byte
        startCmd(8'h38);
        sendAddr(24'h000030);
        sendNibble(4'hA);
        ioO = 4'hB;
        @(negedge clk);
        sck      = 1'b1;
        dbgAddr  = 12'h030;
        dbgWdata = 8'h99;
        dbgWe    = 1'b1;
        @(negedge clk);
        dbgWe    = 1'b0;
        repeat (3) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        sendNibble(4'hC);
        sendNibble(4'hD);
        endXfer();
        backdoorCheck("collision030", 12'h030, 8'h99);
        backdoorCheck("afterCollision031", 12'h031, 8'hCD);

        // Unknown opcode: single cmd_err pulse, then SCK is ignored
        errCycles = 0;
        oeSeen    = 1'b0;
        startCmd(8'h9F);
        for (int i = 0; i < 10; i++) sendNibble(4'h3);
        checkOutput("cmdErrWidth", errCycles, 32'd1);
        checkOutput("discardNoOe", {31'd0, oeSeen}, 32'd0);
        endXfer();
        backdoorCheck("discardNoWrite020", 12'h020, 8'h12);
        backdoorCheck("discardNoWrite000", 12'h000, 8'h55);

        // Abort mid-address, then a clean read
        startCmd(8'hEB);
        sendNibble(4'h0);
        sendNibble(4'h0);
        sendNibble(4'h0);
        endXfer();
        applyStimulus(24'h000010, 32'hDEADBEEF, 8);

        // Reset during read data
        startCmd(8'hEB);
        sendAddr(24'h000010);
        dummyPhase();
        readData(32'h00000DEA, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstOe", {31'd0, oe}, 32'd0);
        checkOutput("rstIo", {28'd0, ioI}, 32'd0);
        rst = 1'b0;
        endXfer();
        applyStimulus(24'h000010, 32'hDEADBEEF, 8);
        backdoorCheck("afterRst020", 12'h020, 8'h12);

        checkOutput("queueEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
